// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared definitions for the UART transmitter: data width, default
//            bit period and the transmit FSM state encoding.
// Config   : UART_TX_PARITY_EN adds the PARITY state to the encoding.
// Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

  localparam int UART_DATA_BITS           = 8;
  localparam int UART_CLK_PER_BIT_DEFAULT = 434;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    ,
    PARITY = 3'd4
`endif
  } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_if
// Purpose  : Valid/ready write channel into the UART transmitter.
// Signals  : tx_data  - byte to send
//            tx_valid - write request
//            tx_ready - transmitter can accept a byte (FIFO not full)
// Modports : master (byte producer), slave (uart_tx)
// Revision : 1.0  initial release
// ============================================================================
interface uart_tx_if;

  logic [uart_pkg::UART_DATA_BITS-1:0] tx_data;
  logic                                tx_valid;
  logic                                tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Small synchronous FIFO buffering bytes ahead of the serialiser.
//            Full/empty come from the registered occupancy, so a push while
//            full is dropped even if a pop happens on the same edge.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            push, wdata       - write request and data
//            pop, rdata        - read request, head-of-queue data (show-ahead)
//            full, empty       - occupancy flags
//            count             - occupancy 0..DEPTH
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wdata,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("uart_tx_fifo: DEPTH must be a power of two and >= 2");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_cw-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign full  = (r_count == c_cw'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign rdata = r_mem[r_rd_ptr];

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointers are exactly log2(DEPTH) bits wide, so they wrap by overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : Buffered UART transmitter. Bytes enter a FIFO over a valid/ready
//            channel and are sent as start, 8 data bits LSB first, optional
//            even parity, and one stop bit. Frames queued back to back leave
//            the line with no idle cycles between them.
// Config   : UART_TX_PARITY_EN - when defined, an even parity bit follows the
//            data bits (11-bit frame); otherwise frames are 10 bits.
// Ports    : clk         - clock, rising edge
//            rst_n       - asynchronous active-low reset
//            bus         - uart_tx_if.slave (tx_data, tx_valid, tx_ready)
//            tx_serial   - registered serial line, idle high
//            tx_busy     - a frame is on the line
//            tx_done     - one-cycle pulse after the last stop-bit cycle
//            fifo_count  - FIFO occupancy
// Revision : 1.0  initial release
// ============================================================================
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = UART_CLK_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  uart_tx_if.slave                          bus,
  output logic                              tx_serial,
  output logic                              tx_busy,
  output logic                              tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int                c_cnt_w    = $clog2(CLK_PER_BIT);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLK_PER_BIT - 1);
  localparam logic [2:0]        c_bit_last = 3'(UART_DATA_BITS - 1);

  if (CLK_PER_BIT < 2) begin : g_chk_clk_per_bit
    $error("uart_tx: CLK_PER_BIT must be >= 2");
  end

  uart_state_e                 r_state,   w_state_nxt;
  logic [c_cnt_w-1:0]          r_cnt,     w_cnt_nxt;
  logic [2:0]                  r_bit_idx, w_bit_idx_nxt;
  logic [UART_DATA_BITS-1:0]   r_shift,   w_shift_nxt;
  logic                        r_serial,  w_serial_nxt;
  logic                        r_done,    w_done_nxt;
`ifdef UART_TX_PARITY_EN
  logic                        r_parity,  w_parity_nxt;
`endif

  logic                        w_pop;
  logic                        w_bit_end;
  logic                        w_fifo_full;
  logic                        w_fifo_empty;
  logic [UART_DATA_BITS-1:0]   w_fifo_rdata;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.tx_valid),
    .wdata (bus.tx_data),
    .pop   (w_pop),
    .rdata (w_fifo_rdata),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (fifo_count)
  );

  assign bus.tx_ready = !w_fifo_full;
  assign tx_serial    = r_serial;
  assign tx_busy      = (r_state != IDLE);
  assign tx_done      = r_done;

  assign w_bit_end    = (r_cnt == c_cnt_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_serial  <= 1'b1;
      r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_serial  <= w_serial_nxt;
      r_done    <= w_done_nxt;
`ifdef UART_TX_PARITY_EN
      r_parity  <= w_parity_nxt;
`endif
    end
  end

  // r_serial holds the level for the bit being timed by r_cnt, so every
  // bit transition sets the next level on the same edge the state changes.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_serial_nxt  = r_serial;
    w_done_nxt    = 1'b0;
    w_pop         = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_parity_nxt  = r_parity;
`endif

    case (r_state)
      IDLE: begin
        w_serial_nxt = 1'b1;
        w_cnt_nxt    = '0;
        w_pop        = !w_fifo_empty;
      end

      START: begin
        if (w_bit_end) begin
          w_cnt_nxt     = '0;
          w_bit_idx_nxt = '0;
          w_serial_nxt  = r_shift[0];
          w_state_nxt   = DATA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          if (r_bit_idx == c_bit_last) begin
`ifdef UART_TX_PARITY_EN
            w_serial_nxt = r_parity;
            w_state_nxt  = PARITY;
`else
            w_serial_nxt = 1'b1;
            w_state_nxt  = STOP;
`endif
          end else begin
            // Shift so the next bit to send is always at position 0.
            w_bit_idx_nxt = r_bit_idx + 1'b1;
            w_shift_nxt   = r_shift >> 1;
            w_serial_nxt  = r_shift[1];
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_end) begin
          w_cnt_nxt    = '0;
          w_serial_nxt = 1'b1;
          w_state_nxt  = STOP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
`endif

      STOP: begin
        if (w_bit_end) begin
          w_cnt_nxt    = '0;
          w_done_nxt   = 1'b1;
          w_serial_nxt = 1'b1;
          w_state_nxt  = IDLE;
          // Chaining straight into the next start bit avoids an idle gap.
          w_pop        = !w_fifo_empty;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt  = IDLE;
        w_serial_nxt = 1'b1;
        w_cnt_nxt    = '0;
      end
    endcase

    // Frame launch is shared by IDLE and the end of STOP: the popped byte is
    // captured here so later tx_data changes cannot reach the frame.
    if (w_pop) begin
      w_state_nxt  = START;
      w_shift_nxt  = w_fifo_rdata;
      w_serial_nxt = 1'b0;
      w_cnt_nxt    = '0;
`ifdef UART_TX_PARITY_EN
      w_parity_nxt = ^w_fifo_rdata;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Self-checking bench for uart_tx. Bytes expected on the line are
//            queued when written and checked bit by bit as frames appear.
//            DUT A runs the default bit period and FIFO depth; DUT B runs a
//            two-clock bit period with a two-entry FIFO.
// Config   : UART_TX_PARITY_EN selects the 11-bit frame expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx;

  localparam int CPB_A = 434;
  localparam int CPB_B = 2;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  uart_tx_if ifa ();
  uart_tx_if ifb ();

  logic       ser_a, busy_a, done_a;
  logic [2:0] cnt_a;
  logic       ser_b, busy_b, done_b;
  logic [1:0] cnt_b;

  int         n_chk = 0;
  int         n_bad = 0;
  logic [7:0] exp_q [$];

  uart_tx #(.CLK_PER_BIT(CPB_A), .FIFO_DEPTH(4)) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (ifa),
    .tx_serial  (ser_a),
    .tx_busy    (busy_a),
    .tx_done    (done_a),
    .fifo_count (cnt_a)
  );

  uart_tx #(.CLK_PER_BIT(CPB_B), .FIFO_DEPTH(2)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (ifb),
    .tx_serial  (ser_b),
    .tx_busy    (busy_b),
    .tx_done    (done_b),
    .fifo_count (cnt_b)
  );

  // Expected line levels of one frame, index 0 = start bit.
  function automatic logic [10:0] frame_bits(input logic [7:0] d);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^d;
`endif
    return f;
  endfunction

  // Called at a negedge; leaves tx_valid high and returns at the next negedge.
  task automatic push_byte(input logic [7:0] d, input bit exp_acc);
    ifa.tx_data  = d;
    ifa.tx_valid = 1'b1;
    n_chk++;
    if (ifa.tx_ready !== exp_acc) begin
      n_bad++;
      $display("FAIL push_ready byte=%02h: tx_ready=%b, required %b", d, ifa.tx_ready, exp_acc);
    end
    if (exp_acc) exp_q.push_back(d);
    @(negedge clk);
  endtask

  // Monitors n frames on DUT A. first_wait < 0 means the first frame's start
  // latency is not checked; later frames must start with no gap.
  task automatic check_frames(input int n, input int first_wait);
    for (int f = 0; f < n; f++) begin
      int          waited;
      int          done_early;
      logic [7:0]  d;
      logic [10:0] bits;
      waited     = 0;
      done_early = 0;
      while (ser_a !== 1'b0 && waited < 3 * CPB_A) begin
        @(negedge clk);
        waited++;
      end
      n_chk++;
      if (ser_a !== 1'b0) begin
        n_bad++;
        $display("FAIL frame_start: serial=%b after %0d cycles, required 0", ser_a, waited);
        return;
      end
      if (f == 0 && first_wait >= 0) begin
        n_chk++;
        if (waited != first_wait) begin
          n_bad++;
          $display("FAIL start_latency: %0d cycles, required %0d", waited, first_wait);
        end
      end else if (f > 0) begin
        n_chk++;
        if (waited != 0) begin
          n_bad++;
          $display("FAIL idle_gap frame=%0d: %0d idle cycles, required 0", f, waited);
        end
      end
      n_chk++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_frame: queue size=%0d, required >0", exp_q.size());
        return;
      end
      d    = exp_q.pop_front();
      bits = frame_bits(d);
      for (int b = 0; b < FRAME_BITS; b++) begin
        int held;
        held = 0;
        for (int c = 0; c < CPB_A; c++) begin
          if (ser_a === bits[b]) held++;
          // The first start-bit cycle may carry the previous frame's done.
          if (done_a !== 1'b0 && !(b == 0 && c == 0)) done_early++;
          @(negedge clk);
        end
        n_chk++;
        if (held != CPB_A) begin
          n_bad++;
          $display("FAIL frame_bit byte=%02h bit=%0d: level %b held %0d cycles, required %0d",
                   d, b, bits[b], held, CPB_A);
        end
      end
      n_chk++;
      if (done_early != 0) begin
        n_bad++;
        $display("FAIL done_in_frame byte=%02h: %0d done cycles, required 0", d, done_early);
      end
      n_chk++;
      if (done_a !== 1'b1) begin
        n_bad++;
        $display("FAIL done_at_end byte=%02h: tx_done=%b, required 1", d, done_a);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({ser_a, busy_a, done_a, ifa.tx_ready, cnt_a} !== 7'b1_0_0_1_000) begin
      n_bad++;
      $display("FAIL reset_a: ser/busy/done/ready/count=%b%b%b%b/%0d, required 1001/0",
               ser_a, busy_a, done_a, ifa.tx_ready, cnt_a);
    end
    n_chk++;
    if ({ser_b, busy_b, done_b, ifb.tx_ready, cnt_b} !== 6'b1_0_0_1_00) begin
      n_bad++;
      $display("FAIL reset_b: ser/busy/done/ready/count=%b%b%b%b/%0d, required 1001/0",
               ser_b, busy_b, done_b, ifb.tx_ready, cnt_b);
    end
    rst_n = 1'b1;
  endtask

  // Write is driven right after reset release, so it lands on the first edge.
  task automatic test_single();
    push_byte(8'h93, 1'b1);
    ifa.tx_valid = 1'b0;
    ifa.tx_data  = 8'hFF;
    n_chk++;
    if (cnt_a !== 3'd1) begin
      n_bad++;
      $display("FAIL single_count: fifo_count=%0d, required 1", cnt_a);
    end
    check_frames(1, 1);
    n_chk++;
    if (busy_a !== 1'b0 || cnt_a !== 3'd0) begin
      n_bad++;
      $display("FAIL single_idle: busy=%b count=%0d, required 0/0", busy_a, cnt_a);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat [6];
    int         occ [6];
    pat = '{8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h3C, 8'hC3};
    occ = '{0, 1, 1, 2, 3, 4};
    fork
      check_frames(5, -1);
      begin
        for (int i = 0; i < 6; i++) begin
          n_chk++;
          if (cnt_a !== 3'(occ[i])) begin
            n_bad++;
            $display("FAIL b2b_count edge=%0d: fifo_count=%0d, required %0d", i + 1, cnt_a, occ[i]);
          end
          push_byte(pat[i], i < 5);
        end
        ifa.tx_valid = 1'b0;
        n_chk++;
        if (cnt_a !== 3'd4) begin
          n_bad++;
          $display("FAIL b2b_full_count: fifo_count=%0d, required 4", cnt_a);
        end
      end
    join
    n_chk++;
    if (busy_a !== 1'b0 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_drain: busy=%b leftover=%0d, required 0/0", busy_a, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int quiet_bad;
    push_byte(8'h93, 1'b1);
    push_byte(8'h11, 1'b1);
    push_byte(8'h22, 1'b1);
    ifa.tx_valid = 1'b0;
    // Frame started one sample ago; move to the middle of data bit 3.
    repeat (4 * CPB_A - 1 + CPB_A / 2) @(negedge clk);
    n_chk++;
    if (ser_a !== 1'b0 || cnt_a !== 3'd2) begin
      n_bad++;
      $display("FAIL mid_bit3: serial=%b count=%0d, required 0/2", ser_a, cnt_a);
    end
    #3 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({ser_a, busy_a, done_a, ifa.tx_ready, cnt_a} !== 7'b1_0_0_1_000) begin
      n_bad++;
      $display("FAIL async_reset: ser/busy/done/ready/count=%b%b%b%b/%0d, required 1001/0",
               ser_a, busy_a, done_a, ifa.tx_ready, cnt_a);
    end
    exp_q.delete();
    quiet_bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_a !== 1'b0 || ser_a !== 1'b1) quiet_bad++;
    end
    rst_n = 1'b1;
    repeat (2 * CPB_A) begin
      @(negedge clk);
      if (done_a !== 1'b0 || ser_a !== 1'b1 || busy_a !== 1'b0) quiet_bad++;
    end
    n_chk++;
    if (quiet_bad != 0) begin
      n_bad++;
      $display("FAIL post_reset_quiet: %0d active cycles, required 0", quiet_bad);
    end
    push_byte(8'h01, 1'b1);
    ifa.tx_valid = 1'b0;
    check_frames(1, 1);
  endtask

  task automatic test_fast();
    logic [7:0]  d;
    logic [10:0] bits;
    int          busy_cycles;
    int          dones;
    ifb.tx_data  = 8'hFF;
    ifb.tx_valid = 1'b1;
    exp_q.push_back(8'hFF);
    @(negedge clk);
    ifb.tx_valid = 1'b0;
    n_chk++;
    if (ser_b !== 1'b1 || cnt_b !== 2'd1) begin
      n_bad++;
      $display("FAIL fast_pre: serial=%b count=%0d, required 1/1", ser_b, cnt_b);
    end
    @(negedge clk);
    d           = exp_q.pop_front();
    bits        = frame_bits(d);
    busy_cycles = 0;
    dones       = 0;
    for (int b = 0; b < FRAME_BITS; b++) begin
      int held;
      held = 0;
      for (int c = 0; c < CPB_B; c++) begin
        if (ser_b === bits[b]) held++;
        if (busy_b === 1'b1) busy_cycles++;
        if (done_b !== 1'b0) dones++;
        @(negedge clk);
      end
      n_chk++;
      if (held != CPB_B) begin
        n_bad++;
        $display("FAIL fast_bit bit=%0d: level %b held %0d cycles, required %0d", b, bits[b], held, CPB_B);
      end
    end
    n_chk++;
    if (done_b !== 1'b1 || dones != 0) begin
      n_bad++;
      $display("FAIL fast_done: tx_done=%b early=%0d, required 1/0", done_b, dones);
    end
    n_chk++;
    if (busy_b !== 1'b0 || busy_cycles != FRAME_BITS * CPB_B) begin
      n_bad++;
      $display("FAIL fast_busy: busy=%b cycles=%0d, required 0/%0d", busy_b, busy_cycles, FRAME_BITS * CPB_B);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, bad=%0d", n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifa.tx_valid = 1'b0;
    ifa.tx_data  = 8'h00;
    ifb.tx_valid = 1'b0;
    ifb.tx_data  = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid();
    test_fast();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 434, clocks per serial bit (115200 baud at 50 MHz); legal range >= 2.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port tx_data  input  8  byte to send, sampled when tx_valid && tx_ready.
REQ-006 SHALL have port tx_valid  input  1  write request.
REQ-007 SHALL have port tx_ready  output  1  FIFO not full; a write is accepted only when tx_valid && tx_ready.
REQ-008 SHALL have port tx_serial  output  1  registered serial line, idle high.
REQ-009 SHALL have port tx_busy  output  1  high while a frame is on the line (any state except IDLE).
REQ-010 SHALL have port tx_done  output  1  one-cycle pulse at the end of each stop bit.
REQ-011 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH+1)  FIFO occupancy.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; each non-IDLE bit lasts exactly CLK_PER_BIT cycles, timed by a 0..CLK_PER_BIT-1 counter.
REQ-013 Transitions SHALL be: IDLE->START when fifo_count != 0; START->DATA; DATA->DATA for 8 bits, then DATA->PARITY (parity compiled in) or DATA->STOP; PARITY->STOP; STOP->START if the FIFO is non-empty at the last stop cycle, else STOP->IDLE.
REQ-014 The pop SHALL occur on the edge that leaves IDLE or STOP for START; the popped byte loads the shift register and tx_serial goes low on that same edge.
REQ-015 A byte accepted at edge N into an empty FIFO with the FSM in IDLE SHALL drive tx_serial low from edge N+1.
REQ-016 Data bits SHALL be sent LSB first; stop bit = 1; back-to-back frames SHALL have no idle cycles between them.
REQ-017 tx_done SHALL be high exactly for the cycle following the last stop-bit cycle, once per frame.
REQ-018 tx_ready SHALL be derived from the registered count: a push while full is ignored, even with a simultaneous pop.
REQ-019 A simultaneous push and pop SHALL leave fifo_count unchanged; read/write pointers wrap modulo FIFO_DEPTH.
REQ-020 Changes to tx_data while a frame is in progress SHALL NOT affect that frame.

Reset
REQ-021 While rst_n is low, regardless of clk: tx_serial=1, tx_busy=0, tx_done=0, tx_ready=1, fifo_count=0, FSM=IDLE, counters 0.
REQ-022 Reset asserted mid-frame SHALL abort the frame, discard FIFO contents, and produce no tx_done.
REQ-023 The first push SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-024 Macro UART_TX_PARITY_EN defined: PARITY state present; even parity bit = XOR of the 8 data bits; frame = 11 bits.
REQ-025 Macro UART_TX_PARITY_EN undefined: PARITY state and its logic absent; frame = 10 bits.

Structure
REQ-026 Shared package uart_pkg SHALL hold the FSM state typedef, UART_DATA_BITS=8, and UART_CLK_PER_BIT_DEFAULT=434.
REQ-027 The FIFO SHALL be a sub-module uart_tx_fifo (parameter DEPTH; push/pop/full/empty/count); the FSM and shifter live in uart_tx.

Verification
REQ-028 Write 0x93 once, parity off -> tx_serial = 0,1,1,0,0,1,0,0,1,1, each level held 434 cycles (8680 ns at 20 ns clk); tx_done pulses 4340 cycles after serial falls.
REQ-029 Same stimulus, UART_TX_PARITY_EN defined -> parity bit 0 inserted before stop; tx_done at 4774 cycles.
REQ-030 tx_valid high for 6 consecutive edges (0x55,0xAA,0x0F,0xF0,0x3C,0xC3) -> first 5 accepted, 0xC3 rejected (tx_ready low at edge 6); five frames back-to-back, 5 tx_done pulses, no idle gap.
REQ-031 rst_n low during data bit 3 of 0x93 with 2 bytes queued -> tx_serial=1 immediately, fifo_count=0, no tx_done; a new write of 0x01 after release transmits correctly.
REQ-032 CLK_PER_BIT=2, write 0xFF -> 20-cycle frame 0,1x8,1; tx_busy high for exactly 20 cycles.
